// File: rtl/leitor_colisao.sv
// Read-side collision checker: scans an 8x8 framebuffer cell through the trail RAM
// read port and reports occupancy, out-of-bounds status and the first occupant code.
module leitor_colisao #(
    parameter int LARGURA_TELA = 640,
    parameter int TAM_CELULA   = 8,
    parameter int LAT_RAM      = 1,
    parameter int ADDR_W       = 19
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        cel_x,
    input  logic [9:0]        cel_y,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              colisao,
    output logic              borda,
    output logic [7:0]        valor_hit
);

    localparam int CW = $clog2(TAM_CELULA);
    localparam logic [CW-1:0]     ULT_POS   = CW'(TAM_CELULA - 1);
    localparam logic [ADDR_W-1:0] PASSO     = ADDR_W'(LARGURA_TELA);
    localparam logic [1:0]        ULT_DRENO = 2'(LAT_RAM - 1);
    localparam logic [9:0]        X_MIN     = 10'd16;
    localparam logic [9:0]        X_MAX     = 10'd623;
    localparam logic [9:0]        Y_MIN     = 10'd16;
    localparam logic [9:0]        Y_MAX     = 10'd463;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LER   = 2'd1,
        DRENO = 2'd2,
        FIM   = 2'd3
    } estado_t;

    estado_t           estado, estado_prox;
    logic [ADDR_W-1:0] linha, linha_prox;
    logic [CW-1:0]     dx, dx_prox, dy, dy_prox;
    logic [1:0]        cnt, cnt_prox;
    logic [ADDR_W-1:0] rd_addr_prox;
    logic              rd_en_prox, busy_prox, done_prox;
    logic              colisao_prox, borda_prox;
    logic [7:0]        valor_prox;
    logic              amostra;
    logic              dentro;
    logic [ADDR_W-1:0] base_ini;

    assign dentro   = (cel_x >= X_MIN) && (cel_x <= X_MAX) && (cel_y >= Y_MIN) && (cel_y <= Y_MAX);
    // Single multiply per request; rows then advance by adding the stride.
    assign base_ini = ADDR_W'(cel_y) * PASSO + ADDR_W'(cel_x);

    // amostra marks the cycle whose rd_data belongs to a scan address issued LAT_RAM cycles ago.
    generate
        if (LAT_RAM == 1) begin : g_lat1
            assign amostra = rd_en;
        end else begin : g_latn
            logic [LAT_RAM-2:0] atraso;

            // Delay line tracking which RAM return cycles carry scan data.
            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset) begin
                    atraso <= {(LAT_RAM-1){1'b0}};
                end else begin
                    atraso[0] <= rd_en;
                    for (int i = 1; i < LAT_RAM - 1; i++) begin
                        atraso[i] <= atraso[i-1];
                    end
                end
            end

            assign amostra = atraso[LAT_RAM-2];
        end
    endgenerate

    // Next-state and next-output logic for the scan controller.
    always_comb begin
        estado_prox  = estado;
        linha_prox   = linha;
        dx_prox      = dx;
        dy_prox      = dy;
        cnt_prox     = cnt;
        rd_addr_prox = {ADDR_W{1'b0}};
        rd_en_prox   = 1'b0;
        busy_prox    = busy;
        done_prox    = 1'b0;
        colisao_prox = colisao;
        borda_prox   = borda;
        valor_prox   = valor_hit;

        case (estado)
            IDLE: begin
                if (start) begin
                    busy_prox    = 1'b1;
                    colisao_prox = 1'b0;
                    borda_prox   = 1'b0;
                    valor_prox   = 8'd0;
                    if (dentro) begin
                        estado_prox = LER;
                        linha_prox  = base_ini;
                        dx_prox     = {CW{1'b0}};
                        dy_prox     = {CW{1'b0}};
                    end else begin
                        estado_prox  = FIM;
                        borda_prox   = 1'b1;
                        colisao_prox = 1'b1;
                    end
                end else begin
                    busy_prox = 1'b0;
                end
            end
            LER: begin
                rd_en_prox   = 1'b1;
                rd_addr_prox = linha + ADDR_W'(dx);
                if (dx == ULT_POS) begin
                    dx_prox    = {CW{1'b0}};
                    linha_prox = linha + PASSO;
                    if (dy == ULT_POS) begin
                        estado_prox = DRENO;
                        cnt_prox    = 2'd0;
                    end else begin
                        dy_prox = dy + CW'(1);
                    end
                end else begin
                    dx_prox = dx + CW'(1);
                end
            end
            DRENO: begin
                if (cnt == ULT_DRENO) begin
                    estado_prox = FIM;
                end else begin
                    cnt_prox = cnt + 2'd1;
                end
            end
            FIM: begin
                done_prox   = 1'b1;
                estado_prox = IDLE;
            end
            default: begin
                estado_prox = IDLE;
            end
        endcase

        // Every sample is examined; only the first nonzero one is kept as the occupant code.
        if (amostra && (rd_data != 8'd0)) begin
            colisao_prox = 1'b1;
            if (valor_hit == 8'd0) begin
                valor_prox = rd_data;
            end else begin
                valor_prox = valor_hit;
            end
        end else begin
            colisao_prox = colisao_prox;
        end
    end

    // State, scan counters and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            estado    <= IDLE;
            linha     <= {ADDR_W{1'b0}};
            dx        <= {CW{1'b0}};
            dy        <= {CW{1'b0}};
            cnt       <= 2'd0;
            rd_addr   <= {ADDR_W{1'b0}};
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            colisao   <= 1'b0;
            borda     <= 1'b0;
            valor_hit <= 8'd0;
        end else begin
            estado    <= estado_prox;
            linha     <= linha_prox;
            dx        <= dx_prox;
            dy        <= dy_prox;
            cnt       <= cnt_prox;
            rd_addr   <= rd_addr_prox;
            rd_en     <= rd_en_prox;
            busy      <= busy_prox;
            done      <= done_prox;
            colisao   <= colisao_prox;
            borda     <= borda_prox;
            valor_hit <= valor_prox;
        end
    end

endmodule

// File: tb/tb_leitor_colisao.sv
// Bench for leitor_colisao: RAM model with configurable read latency, reference
// model of the cell scan, and a scoreboard monitor decoupled from the stimulus.
module tb_leitor_colisao;

    parameter int LAT = 1;
    localparam int W    = 640;
    localparam int NPIX = 307200;
    localparam int TAP  = (LAT > 1) ? LAT - 2 : 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  cel_x, cel_y;
    logic [18:0] rd_addr;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        busy, done, colisao, borda;
    logic [7:0]  valor_hit;

    always #10 clk = ~clk;

    leitor_colisao #(.LARGURA_TELA(640), .TAM_CELULA(8), .LAT_RAM(LAT), .ADDR_W(19)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start),
        .cel_x    (cel_x),
        .cel_y    (cel_y),
        .rd_addr  (rd_addr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .colisao  (colisao),
        .borda    (borda),
        .valor_hit(valor_hit)
    );

    // Trail RAM: data for an address is seen by the reader LAT cycles after it is registered.
    logic [7:0] mem [0:NPIX-1];
    logic [7:0] dado_atual;
    logic [7:0] hist [0:3];

    assign dado_atual = (rd_addr < 19'(NPIX)) ? mem[rd_addr] : 8'h00;

    always @(posedge clk) begin
        hist[0] <= dado_atual;
        for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end

    assign rd_data = (LAT == 1) ? dado_atual : hist[TAP];

    typedef struct {
        bit         colisao;
        bit         borda;
        logic [7:0] valor;
        int         ciclo_done;
    } esperado_t;

    esperado_t exp_q[$];
    int        addr_q[$];
    esperado_t ult;
    int        ciclo = 0;
    int        checks = 0;
    int        falhas = 0;

    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic verifica(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            falhas++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", nome, obtido, esperado, ciclo);
        end
    endtask

    // Reference: the cell is read row-major; result is the first nonzero byte, or a border hit.
    task automatic prever(input int x, input int y, input int e0);
        esperado_t e;
        int a;
        e.colisao = 1'b0;
        e.borda   = 1'b0;
        e.valor   = 8'd0;
        if (x < 16 || x > 623 || y < 16 || y > 463) begin
            e.borda      = 1'b1;
            e.colisao    = 1'b1;
            e.ciclo_done = e0 + 1;
        end else begin
            for (int dy = 0; dy < 8; dy++) begin
                for (int dx = 0; dx < 8; dx++) begin
                    a = (y + dy) * W + x + dx;
                    addr_q.push_back(a);
                    if (mem[a] != 8'd0) begin
                        e.colisao = 1'b1;
                        if (e.valor == 8'd0) e.valor = mem[a];
                    end
                end
            end
            e.ciclo_done = e0 + 65 + LAT;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: checks every scan address, every done, and busy/held results in between.
    always @(negedge clk) begin
        esperado_t e;
        if (rd_en) begin
            if (addr_q.size() == 0) verifica("rd_en_unexpected_reads_pending", addr_q.size(), 1);
            else                    verifica("rd_addr", rd_addr, addr_q.pop_front());
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                verifica("done_unexpected_requests_pending", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                verifica("done_edge", ciclo, e.ciclo_done);
                verifica("colisao", colisao, e.colisao);
                verifica("borda", borda, e.borda);
                verifica("valor_hit", valor_hit, e.valor);
                verifica("reads_missing", addr_q.size(), 0);
                verifica("busy_with_done", busy, 1);
                ult = e;
            end
        end else if (exp_q.size() != 0) begin
            verifica("busy_scan", busy, 1);
        end else begin
            verifica("busy_idle", busy, 0);
            verifica("colisao_held", colisao, ult.colisao);
            verifica("borda_held", borda, ult.borda);
            verifica("valor_hit_held", valor_hit, ult.valor);
        end
    end

    task automatic aguarda_ocioso();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            verifica("timeout_done", exp_q.size(), 0);
            exp_q.delete();
            addr_q.delete();
        end
    endtask

    task automatic espera_ate(input int alvo);
        int n = 0;
        while (ciclo < alvo && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic emite(input int x, input int y, output int aceite);
        aguarda_ocioso();
        cel_x  = 10'(x);
        cel_y  = 10'(y);
        start  = 1'b1;
        aceite = ciclo + 1;
        prever(x, y, aceite);
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic confere_zerado(input string tag);
        verifica({tag, "_rd_addr"}, rd_addr, 0);
        verifica({tag, "_rd_en"}, rd_en, 0);
        verifica({tag, "_busy"}, busy, 0);
        verifica({tag, "_done"}, done, 0);
        verifica({tag, "_colisao"}, colisao, 0);
        verifica({tag, "_borda"}, borda, 0);
        verifica({tag, "_valor_hit"}, valor_hit, 0);
    endtask

    initial begin
        int a;
        reset = 1'b1;
        start = 1'b0;
        cel_x = 10'd0;
        cel_y = 10'd0;
        ult.colisao = 1'b0;
        ult.borda = 1'b0;
        ult.valor = 8'd0;
        ult.ciclo_done = 0;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        confere_zerado("reset");
        reset = 1'b0;
        @(negedge clk); #1;

        // Empty RAM, then two occupied pixels in the same cell.
        emite(216, 240, a);
        aguarda_ocioso();
        mem[243*W + 221] = 8'h01;
        mem[247*W + 223] = 8'h02;
        emite(216, 240, a);

        // Out-of-bounds cells.
        emite(8, 240, a);
        emite(624, 100, a);
        emite(100, 464, a);

        // Bottom-right legal cell.
        aguarda_ocioso();
        mem[470*W + 630] = 8'h05;
        emite(623, 463, a);

        // Starts during a scan are ignored.
        emite(300, 200, a);
        espera_ate(a + 9);
        cel_x = 10'd8;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        espera_ate(a + 39);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;

        // Reset in the middle of a scan, then a normal check.
        emite(400, 300, a);
        espera_ate(a + 29);
        reset = 1'b1;
        #1;
        confere_zerado("midreset");
        exp_q.delete();
        addr_q.delete();
        ult.colisao = 1'b0;
        ult.borda = 1'b0;
        ult.valor = 8'd0;
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
        end
        emite(400, 300, a);

        // Only the last pixel of the cell is occupied.
        aguarda_ocioso();
        mem[107*W + 107] = 8'h7e;
        emite(100, 100, a);

        // Randomized cells and occupancy.
        for (int t = 0; t < 14; t++) begin
            int x, y, n;
            aguarda_ocioso();
            if ($urandom_range(0, 3) == 0) begin
                x = $urandom_range(0, 639);
                y = $urandom_range(0, 479);
            end else begin
                x = $urandom_range(16, 623);
                y = $urandom_range(16, 463);
            end
            if (x + 7 < 640 && y + 7 < 480) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int dy = 0; dy < 8; dy++)
                        for (int dx = 0; dx < 8; dx++)
                            mem[(y + dy)*W + x + dx] = 8'd0;
                end
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++)
                    mem[(y + $urandom_range(0, 7))*W + x + $urandom_range(0, 7)] = 8'($urandom_range(1, 255));
            end
            emite(x, y, a);
        end

        aguarda_ocioso();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, falhas);
        $finish;
    end

endmodule
